// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: state encoding, occupancy codes and default counter width for pipe_stage_skid.
package pipe_stage_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_stage_sat_cnt.sv
// pipe_stage_sat_cnt: saturating up-counter with synchronous active-low clear.
module pipe_stage_sat_cnt
    import pipe_stage_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clock) begin
        if (!clear_n) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered valid/ready pipeline stage with 2-entry skid buffer and flush.
// Defining PIPE_STAGE_PERF_EN adds the CNT_W parameter and a saturating stall_count output.
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int CLEAR_ON_FLUSH = 1
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_count,
`endif
    output logic [1:0]        occupancy
);
    state_t state, state_d;
    logic [DATA_W-1:0] skid, skid_d, data_d;
    logic acc, emit;
    assign acc  = in_valid & in_ready;
    assign emit = out_valid & out_ready;
    always_comb begin
        state_d = state;
        data_d = out_data;
        skid_d = skid;
        case (state)
            ST_EMPTY: if (acc) begin
                state_d = ST_FULL;
                data_d = in_data;
            end
            ST_FULL: if (acc && emit) data_d = in_data;
            else if (acc) begin
                state_d = ST_SKID;
                skid_d = in_data;
            end
            else if (emit) state_d = ST_EMPTY;
            ST_SKID: if (emit) begin
                state_d = ST_FULL;
                data_d = skid;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            data_d = CLEAR_ON_FLUSH != 0 ? RESET_DATA : out_data;
        end
    end
    // Handshake outputs are registered copies of the next state so no ready path crosses the stage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            occupancy <= OCC_EMPTY;
            out_data <= RESET_DATA;
            skid <= RESET_DATA;
        end else begin
            state <= state_d;
            out_valid <= state_d != ST_EMPTY;
            in_ready <= state_d != ST_SKID;
            occupancy <= state_d == ST_SKID ? OCC_TWO : state_d == ST_FULL ? OCC_ONE : OCC_EMPTY;
            out_data <= data_d;
            skid <= skid_d;
        end
    end
`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .clear_n (reset_n),
        .inc     (out_valid & ~out_ready),
        .count   (stall_count)
    );
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed tests of pipe_stage_skid; perf checks run when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;
    localparam logic [31:0] RST_D = 32'h0000_0013;
    logic clock = 1'b0;
    logic reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0] stall_count;
`endif
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;
    pipe_stage_skid #(
        .DATA_W(32),
        .RESET_DATA(RST_D),
        .CLEAR_ON_FLUSH(1)
`ifdef PIPE_STAGE_PERF_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_count(stall_count),
`endif
        .occupancy(occupancy)
    );
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    // Observed tuple is {out_valid, in_ready, occupancy, out_data}.
    task automatic test_reset;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        tick; tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, RST_D}) begin
            errors++;
            $display("FAIL reset: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b0, 1'b1, 2'd0, RST_D});
        end
        reset_n = 1'b1; in_valid = 1'b0;
        tick;
        checks++;
        if ({out_valid, occupancy} !== 3'b0_00) begin
            errors++;
            $display("FAIL reset_no_capture: got %b expected 000", {out_valid, occupancy});
        end
        in_valid = 1'b1; in_data = 32'h77;
        tick;
        reset_n = 1'b0; in_valid = 1'b0;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, RST_D}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b0, 1'b1, 2'd0, RST_D});
        end
        reset_n = 1'b1;
    endtask
    task automatic test_streaming;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            tick;
            checks++;
            if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'(i)}) begin
                errors++;
                $display("FAIL stream_%0d: got %h expected %h", i, {out_valid, in_ready, occupancy, out_data}, {1'b1, 1'b1, 2'd1, 32'(i)});
            end
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0_1_00) begin
            errors++;
            $display("FAIL stream_drain: got %b expected 0100", {out_valid, in_ready, occupancy});
        end
    endtask
    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'hA}) begin
            errors++;
            $display("FAIL bp_first: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b1, 1'b1, 2'd1, 32'hA});
        end
        in_data = 32'hB;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b0, 2'd2, 32'hA}) begin
            errors++;
            $display("FAIL bp_skid: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b1, 1'b0, 2'd2, 32'hA});
        end
        in_data = 32'hC;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b0, 2'd2, 32'hA}) begin
            errors++;
            $display("FAIL bp_hold: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b1, 1'b0, 2'd2, 32'hA});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b1, 1'b1, 2'd1, 32'hB}) begin
            errors++;
            $display("FAIL bp_second: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b1, 1'b1, 2'd1, 32'hB});
        end
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0_1_00) begin
            errors++;
            $display("FAIL bp_drain: got %b expected 0100", {out_valid, in_ready, occupancy});
        end
    endtask
    task automatic test_flush_skid;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick;
        in_data = 32'hB;
        tick;
        in_valid = 1'b0; flush = 1'b1;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, RST_D}) begin
            errors++;
            $display("FAIL flush_skid: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b0, 1'b1, 2'd0, RST_D});
        end
        flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_skid_after_%0d: got out_valid %b expected 0", i, out_valid);
            end
        end
    endtask
    task automatic test_flush_emit_skid;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
        tick;
        in_data = 32'h22;
        tick;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h21}) begin
            errors++;
            $display("FAIL flush_emit_head: got %h expected %h", {out_valid, out_data}, {1'b1, 32'h21});
        end
        tick;
        flush = 1'b0;
        checks++;
        if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, RST_D}) begin
            errors++;
            $display("FAIL flush_emit_drop: got %h expected %h", {out_valid, occupancy, out_data}, {1'b0, 2'd0, RST_D});
        end
    endtask
    task automatic test_flush_accept;
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        tick;
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== {1'b0, 1'b1, 2'd0, RST_D}) begin
            errors++;
            $display("FAIL flush_accept: got %h expected %h", {out_valid, in_ready, occupancy, out_data}, {1'b0, 1'b1, 2'd0, RST_D});
        end
        flush = 1'b0; in_valid = 1'b0;
        tick;
        checks++;
        if ({out_valid, out_data} !== {1'b0, RST_D}) begin
            errors++;
            $display("FAIL flush_accept_after: got %h expected %h", {out_valid, out_data}, {1'b0, RST_D});
        end
    endtask
`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h9;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (stall_count !== 4'd5) begin
            errors++;
            $display("FAIL perf_count: got %0d expected 5", stall_count);
        end
        for (int i = 0; i < 15; i++) tick;
        checks++;
        if (stall_count !== 4'd15) begin
            errors++;
            $display("FAIL perf_saturate: got %0d expected 15", stall_count);
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tick;
        checks++;
        if (stall_count !== 4'd15) begin
            errors++;
            $display("FAIL perf_flush_keep: got %0d expected 15", stall_count);
        end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        checks++;
        if (stall_count !== 4'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d expected 0", stall_count);
        end
    endtask
`endif
    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush_skid;
        test_flush_emit_skid;
        test_flush_accept;
`ifdef PIPE_STAGE_PERF_EN
        test_perf;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
